// File: rtl/rv32m_seq_unit_if.sv
// Execute-stage request/response bundle for the iterative RV32M unit.
// The execute stage is the master; the multiply/divide unit is the slave.
interface rv32m_seq_unit_if;
  logic        start;
  logic [2:0]  m_cnt;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] out;
  logic        ready;

  modport master (output start, m_cnt, rs1, rs2, input out, ready);
  modport slave  (input start, m_cnt, rs1, rs2, output out, ready);
endinterface

// File: rtl/rv32m_seq_unit.sv
// Iterative RV32M unit: 32-step shift-add multiply and restoring divide on magnitudes,
// with the sign fix applied on the final step; divide-by-zero and overflow finish in one cycle.
module rv32m_seq_unit (
  input logic             clk,
  input logic             rst_n,
  rv32m_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [2:0]  op;
  logic [4:0]  cnt;
  logic [31:0] opb;
  logic [63:0] acc;
  logic        neg_res;
  logic        neg_rem;

  logic        rs1_signed;
  logic        rs2_signed;
  logic        rs1_neg;
  logic        rs2_neg;
  logic [31:0] rs1_mag;
  logic [31:0] rs2_mag;
  logic        div_zero;
  logic        div_ovf;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] prod_fin;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;

  always_comb begin
    rs1_signed = (bus.m_cnt == 3'b001) || (bus.m_cnt == 3'b010) ||
                 (bus.m_cnt == 3'b100) || (bus.m_cnt == 3'b110);
    rs2_signed = (bus.m_cnt == 3'b001) || (bus.m_cnt == 3'b100) ||
                 (bus.m_cnt == 3'b110);
    rs1_neg    = rs1_signed & bus.rs1[31];
    rs2_neg    = rs2_signed & bus.rs2[31];
    rs1_mag    = rs1_neg ? -bus.rs1 : bus.rs1;
    rs2_mag    = rs2_neg ? -bus.rs2 : bus.rs2;
    div_zero   = bus.m_cnt[2] && (bus.rs2 == 32'd0);
    div_ovf    = ((bus.m_cnt == 3'b100) || (bus.m_cnt == 3'b110)) &&
                 (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF);
  end

  // One iteration step of each algorithm, plus the signed results of that step
  // which are only committed on the final iteration.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    div_diff = {1'b0, acc[63:32], acc[31]} - {2'b00, opb};
    if (!div_diff[33]) begin
      div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      div_next = {acc[62:0], 1'b0};
    end
    prod_fin = neg_res ? -mul_next : mul_next;
    quo_fin  = neg_res ? -div_next[31:0] : div_next[31:0];
    rem_fin  = neg_rem ? -div_next[63:32] : div_next[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= 3'd0;
      cnt       <= 5'd0;
      opb       <= 32'd0;
      acc       <= 64'd0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      bus.out   <= 32'd0;
      bus.ready <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op  <= bus.m_cnt;
            cnt <= 5'd0;
            if (div_zero) begin
              bus.out   <= bus.m_cnt[1] ? bus.rs1 : 32'hFFFF_FFFF;
              bus.ready <= 1'b1;
              state     <= DONE;
            end else if (div_ovf) begin
              bus.out   <= bus.m_cnt[1] ? 32'd0 : 32'h8000_0000;
              bus.ready <= 1'b1;
              state     <= DONE;
            end else if (bus.m_cnt[2]) begin
              acc     <= {32'd0, rs1_mag};
              opb     <= rs2_mag;
              neg_res <= rs1_neg ^ rs2_neg;
              neg_rem <= rs1_neg;
              state   <= DIV;
            end else begin
              acc     <= {32'd0, rs2_mag};
              opb     <= rs1_mag;
              neg_res <= rs1_neg ^ rs2_neg;
              neg_rem <= 1'b0;
              state   <= MUL;
            end
          end
        end
        MUL: begin
          if (!bus.start) begin
            state <= IDLE;
          end else begin
            acc <= mul_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              bus.out   <= (op == 3'b000) ? prod_fin[31:0] : prod_fin[63:32];
              bus.ready <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DIV: begin
          if (!bus.start) begin
            state <= IDLE;
          end else begin
            acc <= div_next;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              bus.out   <= op[1] ? rem_fin : quo_fin;
              bus.ready <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_seq_unit.sv
// Directed bench for rv32m_seq_unit: hand-computed results and READY latencies
// for multiply, divide, the one-cycle special cases, abort, reset and back-to-back requests.
module tb_rv32m_seq_unit;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  rv32m_seq_unit_if bus ();

  rv32m_seq_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request with START held until READY, scrambling the operand
  // inputs mid-operation since the unit must ignore them after capture.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int expLat,
                               input logic [31:0] expOut, input string tag);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.m_cnt = op;
    bus.rs1   = a;
    bus.rs2   = b;
    checkOutput({tag, "_ready_c"}, {31'd0, bus.ready}, 32'd0);
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.ready) begin
        lat = k;
        break;
      end
      if (k == 5) begin
        bus.rs1   = ~a;
        bus.rs2   = b ^ 32'h0000_1234;
        bus.m_cnt = ~op;
      end
    end
    bus.start = 1'b0;
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_out"}, bus.out, expOut);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {31'd0, bus.ready}, 32'd0);
    checkOutput({tag, "_hold"}, bus.out, expOut);
  endtask

  initial begin
    int readyCount;
    int lat1;
    int lat2;
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.m_cnt   = 3'd0;
    bus.rs1     = 32'd0;
    bus.rs2     = 32'd0;

    repeat (2) @(negedge clk);
    checkOutput("reset_out", bus.out, 32'd0);
    checkOutput("reset_ready", {31'd0, bus.ready}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, "mul");
    applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, "mulh");
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, "mulhu");
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF, "mulhsu");
    applyStimulus(3'b001, 32'hFFFF_FFFE, 32'd3, 33, 32'hFFFF_FFFF, "mulh_neg");

    applyStimulus(3'b101, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, "divu_zero");
    applyStimulus(3'b110, 32'd100, 32'd0, 1, 32'd100, "rem_zero");
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "rem_ovf");

    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, "div");
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, "rem");
    applyStimulus(3'b100, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, "div_negb");
    applyStimulus(3'b101, 32'd100, 32'd7, 33, 32'd14, "divu");
    applyStimulus(3'b111, 32'd100, 32'd7, 33, 32'd2, "remu");

    // Abort: START dropped at cycle c+10 of a divide; OUT keeps the REMU result.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.m_cnt  = 3'b100;
    bus.rs1    = 32'd1000;
    bus.rs2    = 32'd3;
    readyCount = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.ready) readyCount++;
    end
    bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready) readyCount++;
    end
    checkOutput("abort_ready", 32'(readyCount), 32'd0);
    checkOutput("abort_out", bus.out, 32'd2);
    applyStimulus(3'b000, 32'd3, 32'd5, 33, 32'd15, "mul_after_abort");

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1;
    bus.m_cnt = 3'b000;
    bus.rs1   = 32'd9;
    bus.rs2   = 32'd9;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out", bus.out, 32'd0);
    checkOutput("midreset_ready", {31'd0, bus.ready}, 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b000, 32'd6, 32'd7, 33, 32'd42, "mul_after_reset");

    // Back-to-back: MUL then DIVU with START never dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.m_cnt = 3'b000;
    bus.rs1   = 32'd2;
    bus.rs2   = 32'd3;
    lat1 = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.ready) begin
        lat1 = k;
        break;
      end
    end
    checkOutput("b2b_lat1", 32'(lat1), 32'd33);
    checkOutput("b2b_out1", bus.out, 32'd6);
    bus.m_cnt = 3'b101;
    bus.rs1   = 32'd20;
    bus.rs2   = 32'd4;
    lat2 = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.ready) begin
        lat2 = k;
        break;
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b_lat2", 32'(lat2), 32'd34);
    checkOutput("b2b_out2", bus.out, 32'd5);
    @(negedge clk);
    checkOutput("b2b_pulse", {31'd0, bus.ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
